// File: rtl/compress_pkg.sv
// Shared definitions for the compression datapath: default sizes, write-control
// encodings and a helper that counts the writes implied by a control value.
package compress_pkg;

    localparam int WORD_W_DEF = 32;
    localparam int DEPTH_DEF  = 16;

    typedef enum logic [1:0] {
        WR_NONE = 2'b00,
        WR_W0   = 2'b01,
        WR_W1   = 2'b10,
        WR_BOTH = 2'b11
    } wr_ctrl_e;

    function automatic logic [1:0] num_writes(input logic [1:0] ctrl);
        return {1'b0, ctrl[0]} + {1'b0, ctrl[1]};
    endfunction

endpackage

// File: rtl/dict_ptr_ctrl.sv
// Write pointer and occupancy count for the circular dictionary; produces the
// one-hot write enables for the lower (A) and upper (B) slots of this cycle.
module dict_ptr_ctrl
    import compress_pkg::*;
#(
    parameter  int DEPTH = DEPTH_DEF,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_clear,
    input  logic             i_valid,
    input  logic [1:0]       i_wr_control,
    output logic [DEPTH-1:0] o_we_a,
    output logic [DEPTH-1:0] o_we_b,
    output logic [PTR_W-1:0] o_wr_ptr,
    output logic [PTR_W:0]   o_count
);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [PTR_W-1:0] base_ptr, slot_b;
    logic [PTR_W:0]   base_cnt;
    logic [PTR_W+1:0] cnt_sum;
    logic [1:0]       wr_eff;
    logic [1:0]       n_wr;

    // A clear rebases the cycle at an empty dictionary before the write lands.
    always_comb begin
        wr_eff   = i_valid ? i_wr_control : WR_NONE;
        n_wr     = num_writes(wr_eff);
        base_ptr = i_clear ? '0 : wr_ptr_q;
        base_cnt = i_clear ? '0 : count_q;
        slot_b   = base_ptr + PTR_W'(1);
        wr_ptr_d = base_ptr + PTR_W'(n_wr);
        cnt_sum  = {1'b0, base_cnt} + (PTR_W + 2)'(n_wr);
        count_d  = (cnt_sum > (PTR_W + 2)'(DEPTH)) ? (PTR_W + 1)'(DEPTH) : cnt_sum[PTR_W:0];
        o_we_a   = '0;
        o_we_b   = '0;
        if (n_wr != 2'd0) begin
            o_we_a[base_ptr] = 1'b1;
        end
        if (n_wr == 2'd2) begin
            o_we_b[slot_b] = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign o_wr_ptr = wr_ptr_q;
    assign o_count  = count_q;

endmodule

// File: rtl/dictionary_update_unit.sv
// FIFO-replacement dictionary: appends unmatched words of each pair and exposes
// the registered contents and valid mask to the comparators of the next cycle.
module dictionary_update_unit
    import compress_pkg::*;
#(
    parameter  int DEPTH  = DEPTH_DEF,
    parameter  int WORD_W = WORD_W_DEF,
    localparam int PTR_W  = $clog2(DEPTH)
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_clear,
    input  logic                      i_valid,
    input  logic [WORD_W-1:0]         i_word0,
    input  logic [WORD_W-1:0]         i_word1,
    input  logic [1:0]                i_wr_control,
    output logic [DEPTH*WORD_W-1:0]   o_dict,
    output logic [DEPTH-1:0]          o_entry_valid,
    output logic [PTR_W-1:0]          o_wr_ptr,
    output logic [PTR_W:0]            o_count,
    output logic                      o_full
);

    // Handshake: i_valid qualifies the word pair and write control in the cycle
    // it is high; there is no ready, so a pair is accepted on every clock.

    logic [WORD_W-1:0] dict_q [DEPTH];
    logic [WORD_W-1:0] dict_d [DEPTH];
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [DEPTH-1:0]  we_a, we_b;
    logic [WORD_W-1:0] data_a;

    dict_ptr_ctrl #(.DEPTH(DEPTH)) u_ptr_ctrl (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_clear      (i_clear),
        .i_valid      (i_valid),
        .i_wr_control (i_wr_control),
        .o_we_a       (we_a),
        .o_we_b       (we_b),
        .o_wr_ptr     (o_wr_ptr),
        .o_count      (o_count)
    );

    // Slot A takes word0 whenever word0 is written, otherwise the lone word1.
    always_comb begin
        data_a  = i_wr_control[0] ? i_word0 : i_word1;
        valid_d = (i_clear ? '0 : valid_q) | we_a | we_b;
        for (int k = 0; k < DEPTH; k++) begin
            dict_d[k] = dict_q[k];
            if (we_a[k]) begin
                dict_d[k] = data_a;
            end
            if (we_b[k]) begin
                dict_d[k] = i_word1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                dict_q[k] <= '0;
            end
            valid_q <= '0;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                dict_q[k] <= dict_d[k];
            end
            valid_q <= valid_d;
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_flat
        assign o_dict[g*WORD_W +: WORD_W] = dict_q[g];
    end

    assign o_entry_valid = valid_q;
    assign o_full        = (o_count == (PTR_W + 1)'(DEPTH));

endmodule

// File: tb/tb_dictionary_update_unit.sv
// Directed bench for dictionary_update_unit: driver pushes expected snapshots,
// a monitor pops and compares them every cycle, plus hand-valued spot checks.
module tb_dictionary_update_unit;

    localparam int DEPTH  = 16;
    localparam int WORD_W = 32;
    localparam int PTR_W  = 4;
    localparam int DICT_W = DEPTH * WORD_W;
    localparam int SNAP_W = DICT_W + DEPTH + PTR_W + PTR_W + 1 + 1;
    localparam int OFF_MASK = DICT_W;
    localparam int OFF_PTR  = OFF_MASK + DEPTH;
    localparam int OFF_CNT  = OFF_PTR + PTR_W;
    localparam int OFF_FULL = OFF_CNT + PTR_W + 1;

    logic                 clk;
    logic                 reset;
    logic                 clear;
    logic                 valid;
    logic [WORD_W-1:0]    word0;
    logic [WORD_W-1:0]    word1;
    logic [1:0]           wr_control;
    logic [DICT_W-1:0]    dict;
    logic [DEPTH-1:0]     entry_valid;
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W:0]       count;
    logic                 full;

    logic [SNAP_W-1:0]    exp_q[$];
    logic [SNAP_W-1:0]    mon_e;
    int                   n_checks;
    int                   n_fail;

    logic [WORD_W-1:0]    m_dict [DEPTH];
    logic [DEPTH-1:0]     m_mask;
    int                   m_ptr;
    int                   m_cnt;

    dictionary_update_unit #(.DEPTH(DEPTH), .WORD_W(WORD_W)) dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_clear       (clear),
        .i_valid       (valid),
        .i_word0       (word0),
        .i_word1       (word1),
        .i_wr_control  (wr_control),
        .o_dict        (dict),
        .o_entry_valid (entry_valid),
        .o_wr_ptr      (wr_ptr),
        .o_count       (count),
        .o_full        (full)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [DICT_W-1:0] act, input logic [DICT_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [WORD_W-1:0] entry(input int k);
        return dict[k*WORD_W +: WORD_W];
    endfunction

    function automatic logic [SNAP_W-1:0] snapshot();
        logic [DICT_W-1:0] flat;
        for (int k = 0; k < DEPTH; k++) begin
            flat[k*WORD_W +: WORD_W] = m_dict[k];
        end
        return {(m_cnt == DEPTH), (PTR_W + 1)'(m_cnt), PTR_W'(m_ptr), m_mask, flat};
    endfunction

    task automatic model_write(input logic [WORD_W-1:0] w);
        m_dict[m_ptr] = w;
        m_mask[m_ptr] = 1'b1;
        m_ptr = (m_ptr + 1) % DEPTH;
        if (m_cnt < DEPTH) m_cnt++;
    endtask

    // Driver: one cycle of stimulus, expected post-edge state goes to the queue.
    task automatic step(input logic rst, input logic clr, input logic vld, input logic [1:0] ctl,
                        input logic [WORD_W-1:0] w0, input logic [WORD_W-1:0] w1);
        @(negedge clk);
        reset = rst; clear = clr; valid = vld; wr_control = ctl; word0 = w0; word1 = w1;
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) m_dict[k] = '0;
            m_mask = '0; m_ptr = 0; m_cnt = 0;
        end else begin
            if (clr) begin
                m_mask = '0; m_ptr = 0; m_cnt = 0;
            end
            if (vld && ctl[0]) model_write(w0);
            if (vld && ctl[1]) model_write(w1);
        end
        exp_q.push_back(snapshot());
        @(posedge clk);
        #1;
        reset = 1'b0; clear = 1'b0; valid = 1'b0;
    endtask

    // Monitor: outputs are registered, so every post-edge state is compared.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("dict",        dict,                          mon_e[DICT_W-1:0]);
            check("entry_valid", DICT_W'(entry_valid),          DICT_W'(mon_e[OFF_PTR-1:OFF_MASK]));
            check("wr_ptr",      DICT_W'(wr_ptr),               DICT_W'(mon_e[OFF_CNT-1:OFF_PTR]));
            check("count",       DICT_W'(count),                DICT_W'(mon_e[OFF_FULL-1:OFF_CNT]));
            check("full",        DICT_W'(full),                 DICT_W'(mon_e[OFF_FULL]));
        end
    end

    initial begin
        n_checks = 0; n_fail = 0;
        for (int k = 0; k < DEPTH; k++) m_dict[k] = '0;
        m_mask = '0; m_ptr = 0; m_cnt = 0;
        reset = 1'b1; clear = 1'b0; valid = 1'b0; wr_control = 2'b00; word0 = '0; word1 = '0;

        step(1, 0, 0, 2'b00, 0, 0);
        step(1, 0, 0, 2'b00, 0, 0);
        #1;
        check("reset_count", DICT_W'(count), 0);
        check("reset_dict",  dict, 0);

        for (int i = 0; i < 3; i++) step(0, 0, 1, 2'b01, 32'hA0 + i, 32'hFFFF);
        #1;
        check("a_entry0", DICT_W'(entry(0)), 32'hA0);
        check("a_entry2", DICT_W'(entry(2)), 32'hA2);
        check("a_mask",   DICT_W'(entry_valid), 16'h0007);
        check("a_ptr",    DICT_W'(wr_ptr), 3);

        step(0, 0, 1, 2'b01, 32'hA3, 0);
        step(0, 0, 1, 2'b01, 32'hA4, 0);
        step(0, 0, 1, 2'b11, 32'h11, 32'h22);
        step(0, 0, 1, 2'b10, 32'hEE, 32'h33);
        #1;
        check("pair_entry5", DICT_W'(entry(5)), 32'h11);
        check("pair_entry6", DICT_W'(entry(6)), 32'h22);
        check("w1_entry7",   DICT_W'(entry(7)), 32'h33);
        check("w1_ptr",      DICT_W'(wr_ptr), 8);

        for (int i = 0; i < 7; i++) step(0, 0, 1, 2'b01, 32'hC0 + i, 0);
        #1;
        check("fill_count", DICT_W'(count), 15);
        step(0, 0, 1, 2'b11, 32'hBB, 32'hCC);
        #1;
        check("wrap_entry15", DICT_W'(entry(15)), 32'hBB);
        check("wrap_entry0",  DICT_W'(entry(0)), 32'hCC);
        check("wrap_ptr",     DICT_W'(wr_ptr), 1);
        check("wrap_full",    DICT_W'(full), 1);

        step(0, 0, 1, 2'b11, 32'hD0, 32'hD1);
        #1;
        check("ovw_entry1", DICT_W'(entry(1)), 32'hD0);
        check("ovw_count",  DICT_W'(count), 16);

        while (m_ptr != DEPTH - 2) step(0, 0, 1, 2'b01, $urandom, 0);
        step(0, 0, 1, 2'b11, 32'hE0, 32'hE1);
        #1;
        check("edge_ptr0", DICT_W'(wr_ptr), 0);

        step(0, 1, 1, 2'b11, 32'h55, 32'h66);
        #1;
        check("clr_mask",  DICT_W'(entry_valid), 16'h0003);
        check("clr_count", DICT_W'(count), 2);
        check("clr_entry1", DICT_W'(entry(1)), 32'h66);

        for (int i = 0; i < 10; i++) step(0, 0, 0, 2'b11, 32'h1234, 32'h5678);
        #1;
        check("idle_ptr", DICT_W'(wr_ptr), 2);

        step(0, 1, 0, 2'b11, 0, 0);
        step(0, 0, 1, 2'b01, 32'h77, 0);
        step(1, 1, 1, 2'b11, 32'h88, 32'h99);
        #1;
        check("rst_mid_count", DICT_W'(count), 0);
        check("rst_mid_entry0", DICT_W'(entry(0)), 0);
        step(0, 0, 1, 2'b11, 32'h88, 32'h99);
        #1;
        check("post_rst_ptr", DICT_W'(wr_ptr), 2);

        repeat (2) @(posedge clk);
        #2;
        check("queue_drained", DICT_W'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dictionary_update_unit.md
Name: dictionary_update_unit

Overview:
- FIFO-replacement dictionary store for the two-word-per-cycle compression datapath.
- Consumes the 2-bit write-control vector from the control signal generator, together with the two input words of the same cycle.
- Appends each unmatched word to a circular dictionary and presents the full contents, plus a per-entry valid mask, to the stage-1/stage-3 comparators for the next cycle.
- A clear pulse at each cache-line boundary empties the dictionary.

Parameters:
- DEPTH, 16, number of dictionary entries; power of two, at least 2.
- WORD_W, 32, width of one dictionary word.
- PTR_W, $clog2(DEPTH), derived localparam; width of the write pointer.

Ports:
- i_clk  input  1  clock; the block uses this one clock only.
- i_reset  input  1  reset; synchronous and active-high.
- i_clear  input  1  start of a new cache line; empties the dictionary.
- i_valid  input  1  the word pair and write control are valid this cycle.
- i_word0  input  WORD_W  first word of the pair.
- i_word1  input  WORD_W  second word of the pair.
- i_wr_control  input  2  bit0: write i_word0; bit1: write i_word1.
- o_dict  output  DEPTH*WORD_W  flattened dictionary; entry k occupies bits [k*WORD_W +: WORD_W].
- o_entry_valid  output  DEPTH  bit k set when entry k holds a word written since the last clear or reset.
- o_wr_ptr  output  PTR_W  index of the next entry to be written.
- o_count  output  PTR_W+1  number of valid entries, 0..DEPTH.
- o_full  output  1  o_count == DEPTH.

Behaviour:
- Reset values: o_dict all zero, o_entry_valid 0, o_wr_ptr 0, o_count 0, o_full 0.
- All outputs are registered. A write accepted in cycle N is visible on the outputs in cycle N+1. There is no combinational path from inputs to outputs.
- When i_valid=0, i_wr_control is ignored and the state holds, unless i_clear is asserted.
- Write cases when i_valid=1, with P = current o_wr_ptr:
  - 2'b00: no change.
  - 2'b01: entry[P] <= i_word0; ptr <= P+1.
  - 2'b10: entry[P] <= i_word1; ptr <= P+1.
  - 2'b11: entry[P] <= i_word0; entry[P+1] <= i_word1; ptr <= P+2.
  - i_word0 always takes the lower slot, preserving stream order.
- Pointer arithmetic is modulo DEPTH, using natural PTR_W-bit wrap:
  - P=DEPTH-1 with two writes puts word0 in entry DEPTH-1 and word1 in entry 0, and the pointer becomes 1.
  - P=DEPTH-2 with two writes leaves the pointer at 0.
- When full, writes overwrite the oldest entries (FIFO replacement).
- o_count += number of writes, saturating at DEPTH.
- Every written entry sets its o_entry_valid bit.
- i_clear=1: pointer, count and o_entry_valid are zeroed. Entry data is not cleared, since comparators must qualify matches with o_entry_valid.
- i_clear=1 with i_valid=1 in the same cycle: the clear applies first, then the write with P=0. Example: clear with 2'b11 gives entries 0 and 1 written, ptr=2, count=2, valid mask 0x0003.
- i_reset overrides i_clear and i_valid in any cycle.
- Reset mid-stream discards all contents. The first cycle after reset deassertion behaves as on an empty dictionary.
- o_full is derived from the registered count and reflects the same cycle as o_count.
- No backpressure: the block accepts a pair every cycle.

Decomposition:
- Shared package compress_pkg:
  - WORD_W and DEPTH defaults.
  - Write-control encodings: WR_NONE=2'b00, WR_W0=2'b01, WR_W1=2'b10, WR_BOTH=2'b11.
  - Function for the number of writes implied by a write-control value.
- One sub-module, dict_ptr_ctrl, holds the pointer and count registers, wrap and saturation logic, and produces the two per-entry write-enable one-hot vectors.
- The top level holds the entry array and the valid mask.

Test Plan:
- Reset, then valid cycles with 2'b01 carrying words 0xA0..0xA2 -> entries 0..2 = 0xA0,0xA1,0xA2; ptr=3, count=3, valid mask 0x0007; the write is visible exactly one cycle after acceptance.
- Pair cycle 2'b11 with word0=0x11, word1=0x22 at ptr=5 -> entry5=0x11, entry6=0x22, ptr=7. Pair cycle 2'b10 with word1=0x33 -> entry7=0x33, ptr=8.
- Fill to ptr=15, count=15, then 2'b11 with 0xBB/0xCC -> entry15=0xBB, entry0=0xCC, ptr=1, count=16, o_full=1. Further writes keep count=16 and overwrite entry1 onward.
- i_clear together with i_valid, 2'b11, words 0x55/0x66, on a full dictionary -> next cycle ptr=2, count=2, valid mask 0x0003, entries 0,1 = 0x55,0x66.
- i_valid=0 with i_wr_control=2'b11 for 10 cycles -> outputs unchanged. Then i_reset asserted for one cycle mid-stream -> all outputs at reset values on the next cycle.
